// File: rtl/audio_pkg.sv
// Shared types and defaults for the tone PWM audio path.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int SAMPLE_W_DEF = 7;
  localparam int DUR_W_DEF    = 10;
  localparam int CLK_HZ_DEF   = 50000000;

  // Clock cycles per millisecond for a given clock frequency.
  function automatic int ms_div(input int clk_hz);
    return clk_hz / 1000;
  endfunction

endpackage

// File: rtl/tone_pwm_driver_pwm_core.sv
// Free-running PWM counter with a once-per-period sample latch and compare.
module pwm_core
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic                wrap,
  output logic                sample_strobe,
  output logic                pwm_raw
);

  localparam logic [SAMPLE_W-1:0] CNT_MAX = '1;

  logic [SAMPLE_W-1:0] pwm_cnt;
  logic [SAMPLE_W-1:0] sample_q;

  assign wrap = (pwm_cnt == CNT_MAX);

  // Sample is only taken at the wrap so a period never mixes two duty values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt       <= '0;
      sample_q      <= '0;
      sample_strobe <= 1'b0;
    end else begin
      pwm_cnt       <= pwm_cnt + 1'b1;
      sample_strobe <= wrap;
      if (wrap) begin
        sample_q <= sample_in;
      end
    end
  end

  assign pwm_raw = (pwm_cnt < sample_q);

endmodule

// File: rtl/tone_pwm_driver.sv
// Gates a sample-driven PWM stream for a programmable number of milliseconds,
// always finishing the tone on a PWM period boundary.
module tone_pwm_driver
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int CLK_HZ   = CLK_HZ_DEF,
  parameter int DUR_W    = DUR_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                play_req,
  input  logic [DUR_W-1:0]    play_ms,
  input  logic                mute,
  output logic                busy,
  output logic                sample_strobe,
  output logic                pwm_out,
  output logic                audio_en
);

  localparam int MS_DIV = ms_div(CLK_HZ);
  localparam int PRE_W  = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(MS_DIV - 1);

  state_t             state, state_n;
  logic [DUR_W-1:0]   ms_left, ms_left_n;
  logic [PRE_W-1:0]   prescale, prescale_n;
  logic               wrap;
  logic               pwm_raw;
  logic               reload;

  pwm_core #(
    .SAMPLE_W(SAMPLE_W)
  ) u_pwm_core (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .wrap         (wrap),
    .sample_strobe(sample_strobe),
    .pwm_raw      (pwm_raw)
  );

  assign reload = play_req && (play_ms != '0);

  // A reload beats the millisecond decrement, so retriggers restart cleanly.
  always_comb begin
    state_n    = state;
    ms_left_n  = ms_left;
    prescale_n = prescale;
    case (state)
      IDLE: begin
        if (reload) begin
          state_n    = PLAY;
          ms_left_n  = play_ms;
          prescale_n = '0;
        end
      end
      PLAY: begin
        if (reload) begin
          ms_left_n  = play_ms;
          prescale_n = '0;
        end else if (prescale == PRE_MAX) begin
          prescale_n = '0;
          ms_left_n  = ms_left - 1'b1;
          if (ms_left == DUR_W'(1)) begin
            state_n = DRAIN;
          end
        end else begin
          prescale_n = prescale + 1'b1;
        end
      end
      DRAIN: begin
        if (reload) begin
          state_n    = PLAY;
          ms_left_n  = play_ms;
          prescale_n = '0;
        end else if (wrap) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ms_left  <= '0;
      prescale <= '0;
      pwm_out  <= 1'b0;
    end else begin
      state    <= state_n;
      ms_left  <= ms_left_n;
      prescale <= prescale_n;
      pwm_out  <= pwm_raw & (state != IDLE) & ~mute;
    end
  end

  assign busy     = (state != IDLE);
  assign audio_en = busy & ~mute;

endmodule

// File: tb/tb_tone_pwm_driver.sv
// Scoreboard bench for tone_pwm_driver: a timeline model predicts every cycle's outputs.
module tb_tone_pwm_driver;

  localparam int SW     = 7;
  localparam int DW     = 10;
  localparam int CLK_HZ = 4000;
  localparam int MSD    = CLK_HZ / 1000;
  localparam int PER    = 1 << SW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [SW-1:0] sample_in = '0;
  logic          play_req = 1'b0;
  logic [DW-1:0] play_ms = '0;
  logic          mute = 1'b0;
  logic          busy, sample_strobe, pwm_out, audio_en;

  tone_pwm_driver #(.SAMPLE_W(SW), .CLK_HZ(CLK_HZ), .DUR_W(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .play_req     (play_req),
    .play_ms      (play_ms),
    .mute         (mute),
    .busy         (busy),
    .sample_strobe(sample_strobe),
    .pwm_out      (pwm_out),
    .audio_en     (audio_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit busy;
    bit strobe;
    bit pwm;
    bit aen;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Timeline model: times are absolute cycle numbers, phase is time since reset mod PER.
  int cyc = 0;
  int origin = 0;
  bit have_prev = 0;
  bit prev_reset, prev_req, prev_mute, prev_busy;
  int prev_ms, prev_sample, prev_phase;
  int sq = 0;
  bit tone_on = 0;
  int play_end = 0;
  int tone_last = 0;

  function automatic int phaseAt(input int c, input int org);
    return (c - org) % PER;
  endfunction

  task modelStep();
    exp_t e;
    bit b, pw, st;
    b = 0; pw = 0; st = 0;
    if (have_prev) begin
      if (prev_reset) begin
        origin  = cyc;
        tone_on = 0;
        sq      = 0;
      end else begin
        pw = prev_busy && !prev_mute && (prev_phase < sq);
        st = (prev_phase == PER - 1);
        if (st) sq = prev_sample;
        if (prev_req && prev_ms != 0) begin
          play_end  = cyc + prev_ms * MSD;
          tone_last = play_end + (PER - 1 - phaseAt(play_end, origin));
          tone_on   = 1;
        end
        if (tone_on && cyc > tone_last) tone_on = 0;
        b = tone_on;
      end
      e.cyc = cyc; e.busy = b; e.strobe = st; e.pwm = pw; e.aen = b && !mute;
      sb.push_back(e);
      prev_busy  = b;
      prev_phase = phaseAt(cyc, origin);
    end
    prev_reset  = reset;
    prev_req    = play_req;
    prev_ms     = int'(play_ms);
    prev_sample = int'(sample_in);
    prev_mute   = mute;
    have_prev   = 1;
    cyc++;
  endtask

  task automatic applyStimulus(input bit r, input int s, input bit req, input int ms, input bit m);
    @(posedge clk);
    #1;
    reset     = r;
    sample_in = s[SW-1:0];
    play_req  = req;
    play_ms   = ms[DW-1:0];
    mute      = m;
    modelStep();
  endtask

  task automatic idleCycles(input int n, input int s, input bit m);
    for (int i = 0; i < n; i++) applyStimulus(0, s, 0, 0, m);
  endtask

  task automatic checkBit(input string name, input int c, input logic act, input bit req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, c, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkBit("busy", e.cyc, busy, e.busy);
    checkBit("sample_strobe", e.cyc, sample_strobe, e.strobe);
    checkBit("pwm_out", e.cyc, pwm_out, e.pwm);
    checkBit("audio_en", e.cyc, audio_en, e.aen);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int s;
    bit m;
    // Scenario 1: reset, then idle with a steady sample.
    for (int i = 0; i < 3; i++) applyStimulus(1, 64, 0, 0, 0);
    idleCycles(512, 64, 0);
    // Scenario 2: short tone at sample 32.
    applyStimulus(0, 32, 1, 3, 0);
    idleCycles(300, 32, 0);
    // Scenario 3: extreme duty values over long tones.
    applyStimulus(0, 0, 1, 100, 0);
    idleCycles(560, 0, 0);
    applyStimulus(0, 127, 1, 100, 0);
    idleCycles(560, 127, 0);
    // Scenario 4: retrigger after 3 ms, then a zero-length request.
    applyStimulus(0, 90, 1, 5, 0);
    idleCycles(11, 90, 0);
    applyStimulus(0, 90, 1, 5, 0);
    idleCycles(200, 90, 0);
    applyStimulus(0, 90, 1, 0, 0);
    idleCycles(20, 90, 0);
    // Scenario 5: mute window inside a tone.
    applyStimulus(0, 64, 1, 50, 0);
    idleCycles(20, 64, 0);
    idleCycles(120, 64, 1);
    idleCycles(250, 64, 0);
    // Scenario 6: reset in the middle of PLAY, then a fresh tone.
    applyStimulus(0, 50, 1, 10, 0);
    idleCycles(15, 50, 0);
    applyStimulus(1, 50, 0, 0, 0);
    applyStimulus(0, 50, 1, 2, 0);
    idleCycles(300, 50, 0);
    // Randomized traffic, including retriggers in DRAIN and sample changes mid-period.
    m = 0;
    for (int i = 0; i < 2000; i++) begin
      s = int'($urandom_range(0, PER - 1));
      if ($urandom_range(0, 29) == 0) m = ~m;
      if ($urandom_range(0, 499) == 0)
        applyStimulus(1, s, 0, 0, m);
      else if ($urandom_range(0, 39) == 0)
        applyStimulus(0, s, 1, int'($urandom_range(0, 6)), m);
      else
        applyStimulus(0, s, 0, 0, m);
    end
    idleCycles(300, 10, 0);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tone_pwm_driver.md
Name: tone_pwm_driver

Overview:
- Consumes the 7-bit unsigned sample stream from the sine-wave peripheral (sine_wave_output_readdata) and converts it to a 1-bit PWM audio signal for the board speaker/GPIO pin.
- Software or game logic triggers a tone of a programmable duration in milliseconds, for example a paddle hit or a score.
- The block gates the PWM for that duration and ends every tone on a PWM period boundary, so no truncated pulse reaches the speaker.

Parameters:
- SAMPLE_W, 7, width of sample_in and of the PWM compare; PWM period = 2^SAMPLE_W cycles.
- CLK_HZ, 50000000, clk frequency; MS_DIV = CLK_HZ/1000 cycles per millisecond (constant, must be >= 1).
- DUR_W, 10, width of play_ms (max 1023 ms).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sample_in  in  SAMPLE_W  unsigned sample from sine-wave generator
- play_req  in  1  single-cycle tone start/retrigger pulse
- play_ms  in  DUR_W  tone duration in ms, sampled when play_req=1
- mute  in  1  level; forces pwm_out low, timing unaffected
- busy  out  1  high while a tone is active or draining
- sample_strobe  out  1  one-cycle pulse when a new sample is latched
- pwm_out  out  1  PWM audio output
- audio_en  out  1  high while tone is audible (busy & ~mute)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. All state updates on rising clk edge.
- Reset:
  - pwm_cnt=0, sample_q=0, state=IDLE, ms_left=0, prescale=0.
  - Outputs busy=0, sample_strobe=0, pwm_out=0, audio_en=0.
- PWM counter:
  - pwm_cnt (SAMPLE_W bits) free-runs 0..2^SAMPLE_W-1 and wraps, in every state.
  - When pwm_cnt==max, sample_q<=sample_in and sample_strobe=1 on the following cycle (the cycle pwm_cnt==0). sample_strobe is registered.
  - sample_q is updated only at wrap, so a mid-period change of sample_in has no effect until the next period.
- Compare:
  - pwm_raw = (pwm_cnt < sample_q).
  - sample_q=0 gives always low. sample_q=127 gives high for 127 of 128 cycles.
  - pwm_out is registered: pwm_out <= pwm_raw & (state!=IDLE) & ~mute. This adds 1 cycle latency from counter to pin.
- FSM states: IDLE, PLAY, DRAIN.
  - IDLE: on play_req=1 with play_ms!=0, load ms_left=play_ms and prescale=0, then go to PLAY. play_req with play_ms==0 is ignored.
  - PLAY:
    - prescale counts 0..MS_DIV-1. At MS_DIV-1, prescale returns to 0 and ms_left decrements.
    - When ms_left==1 and prescale==MS_DIV-1, go to DRAIN.
    - play_req with play_ms!=0 retriggers: reload ms_left, prescale=0, stay in PLAY. This takes priority over the decrement in the same cycle.
    - play_req with play_ms==0 is ignored.
  - DRAIN: stay until pwm_cnt==max, then go to IDLE. play_req with play_ms!=0 in DRAIN returns to PLAY with a reload, same as retrigger.
- Outputs:
  - busy = (state!=IDLE), registered with the state.
  - audio_en = busy & ~mute.
- Duration accuracy: PLAY lasts exactly play_ms*MS_DIV cycles. DRAIN adds 1..2^SAMPLE_W cycles.
- Mute:
  - Asserting mute mid-tone drops pwm_out on the next cycle.
  - Counters keep running, and the tone ends at the same time it would have unmuted.
- Reset mid-tone: return to IDLE immediately on the next edge; pwm_out=0 on that edge. No drain.

Decomposition:
- Shared package (audio_pkg): FSM state enum (IDLE/PLAY/DRAIN, 2-bit encoding), SAMPLE_W and DUR_W defaults, and an MS_DIV helper function.
- One natural sub-module: pwm_core. It holds the free-running counter, the sample latch, sample_strobe and the compare. The top holds the FSM, prescaler and ms counter.

Test Plan (bench uses CLK_HZ=4000 so MS_DIV=4, SAMPLE_W=7, DUR_W=10):
1. Reset, then sample_in=64, no play_req for 512 cycles -> pwm_out=0, busy=0, sample_strobe every 128 cycles, sample_q=64.
2. sample_in=32, play_req with play_ms=3 -> busy rises the next cycle. PLAY lasts 12 cycles, then DRAIN until the next wrap. pwm_out is high exactly 32 cycles per full period, 1-cycle latency from pwm_cnt.
3. sample_in=0, then 127, each held across a full tone of play_ms=100 -> sample 0 gives 0 high cycles per period; sample 127 gives 127 high cycles and 1 low cycle per period.
4. play_ms=5; retrigger play_req with play_ms=5 after 3 ms -> PLAY total = 8 ms = 32 cycles. Also play_req with play_ms=0 in IDLE -> busy stays 0.
5. mute=1 during a tone of play_ms=50 with sample_in=64 -> pwm_out=0 and audio_en=0 while busy=1; busy deasserts at the same cycle as the unmuted reference run.
6. reset pulse in the middle of PLAY -> next cycle state=IDLE, busy=0, pwm_out=0, pwm_cnt=0; a subsequent play_req with play_ms=2 behaves as in scenario 2.
